snoop_responder: RTL
====================

SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_W, 8, snoop address width.
- BEATS, 4, data beats supplied per snoop hit; legal range 1..16.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- snoop_in, in, 1, snoop request from the remote cache controller (its snoop_out).
- bus_func, in, 2, remote bus function:
  - 2'b10 = b_read (GetS).
  - 2'b01 = p_write (GetX/invalidate).
  - 2'b00 and 2'b11 = not snoops.
- bus_addr, in, ADDR_W, snooped line address.
- lk_req, out, 1, local tag/state lookup strobe.
- lk_addr, out, ADDR_W, lookup address.
- lk_tag_match, in, 1, local tag match, valid in the cycle lk_req=1.
- lk_stat, in, 2, local line state, valid in the cycle lk_req=1:
  - 2'b11 = excl.
  - 2'b10 = shrd.
  - 2'b00 = invl.
- data_rd, out, 1, read local data word and drive it onto the bus this cycle.
- beat_idx, out, 4, word index of the current beat.
- st_wr, out, 1, local state write strobe.
- st_new, out, 2, new local state written when st_wr=1.
- snoop_hit, out, 1, remote line held locally; valid only while snoop_ready=1.
- snoop_ready, out, 1, snoop response complete; one-cycle pulse.
- busy, out, 1, responder not in IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, LOOKUP, DRIVE, UPDATE and DONE.
REQ-004 In IDLE, when snoop_in=1 and bus_func is 2'b10 or 2'b01, the block SHALL:
- capture bus_addr and bus_func;
- move to LOOKUP.
REQ-005 In IDLE, when bus_func is 2'b00 or 2'b11, the block SHALL ignore snoop_in and remain in IDLE.
REQ-006 In LOOKUP (exactly 1 cycle), the block SHALL:
- assert lk_req=1 with lk_addr equal to the captured address;
- register hit = lk_tag_match && (lk_stat != 2'b00);
- register lk_stat.
REQ-007 On leaving LOOKUP, the FSM SHALL go to DRIVE on hit, or to DONE on miss.
REQ-008 DRIVE SHALL last exactly BEATS cycles:
- data_rd=1 in every DRIVE cycle;
- beat_idx counts 0..BEATS-1, incrementing by one per cycle;
- beat_idx is 0 outside DRIVE;
- the FSM moves to UPDATE after beat BEATS-1.
REQ-009 UPDATE SHALL last exactly 1 cycle, with st_wr and st_new set by captured bus_func and registered stat:
- captured func b_read, stat excl: st_wr=1, st_new=2'b10.
- captured func b_read, stat shrd: st_wr=0.
- captured func p_write, any hit: st_wr=1, st_new=2'b00.
REQ-010 DONE SHALL last exactly 1 cycle with snoop_ready=1 and snoop_hit equal to the registered hit, then return to IDLE.
REQ-011 The response latency, counted from the IDLE capture edge to the cycle with snoop_ready=1, SHALL be:
- 2 cycles on a miss;
- BEATS+3 cycles on a hit.
REQ-012 Once captured, a transaction SHALL complete unchanged:
- deassertion of snoop_in mid-transaction has no effect;
- changes to bus_addr or bus_func mid-transaction have no effect.
REQ-013 snoop_in still asserted in the cycle after DONE (i.e., in IDLE) SHALL start a new transaction, back-to-back with no bubble beyond DONE.
REQ-014 busy SHALL equal 1 in every state except IDLE.
REQ-015 lk_req, data_rd, st_wr, snoop_ready and snoop_hit SHALL be 0 in every state not listed for them above.
REQ-016 st_new SHALL be 2'b00 whenever st_wr=0.
REQ-017 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.
REQ-018 lk_tag_match and lk_stat SHALL be ignored outside LOOKUP.

Reset
REQ-019 While reset=1, the block SHALL asynchronously force:
- state to IDLE;
- beat counter to 0;
- captured address, func, hit and stat registers to 0;
- all outputs to 0.
REQ-020 Reset asserted mid-transaction SHALL abort it:
- no further data_rd, st_wr or snoop_ready is issued for that transaction;
- the first transaction after reset deassertion is accepted starting from IDLE.

Verification
REQ-021 Miss: snoop_in=1, bus_func=2'b10, lk_tag_match=0. Required response:
- lk_req=1 on edge+1;
- snoop_ready=1 and snoop_hit=0 on edge+2;
- no data_rd, no st_wr.
REQ-022 Excl read snoop: bus_func=2'b10, lk_tag_match=1, lk_stat=2'b11, BEATS=4. Required response:
- data_rd for 4 cycles with beat_idx 0,1,2,3;
- st_wr=1 with st_new=2'b10;
- snoop_ready=1 and snoop_hit=1 at edge+7.
REQ-023 Shared invalidate: bus_func=2'b01, lk_tag_match=1, lk_stat=2'b10. Required response:
- 4 data beats;
- st_wr=1 with st_new=2'b00;
- snoop_hit=1.
REQ-024 Shared read snoop: bus_func=2'b10, lk_stat=2'b10 hit. Required response:
- 4 data beats;
- st_wr stays 0;
- snoop_hit=1.
REQ-025 Held request: snoop_in held at 1 across DONE. Required response: a second LOOKUP in the cycle after IDLE; snoop_in dropped during DRIVE still yields full beats and snoop_ready.
REQ-026 Reset pulse during DRIVE beat 1. Required response:
- all outputs 0 immediately;
- no st_wr or snoop_ready afterwards;
- a new miss snoop after reset completes in 2 cycles.

Source files
------------

// File: rtl/snoop_responder_if.sv
// Snoop bus bundle between a remote cache controller and the local snoop responder.
// The master side drives the snoop request and lookup results; the slave side is the responder.
interface snoop_responder_if #(
  parameter int ADDR_W = 8
);
  logic              snoop_in;
  logic [1:0]        bus_func;
  logic [ADDR_W-1:0] bus_addr;
  logic              lk_req;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_tag_match;
  logic [1:0]        lk_stat;
  logic              data_rd;
  logic [3:0]        beat_idx;
  logic              st_wr;
  logic [1:0]        st_new;
  logic              snoop_hit;
  logic              snoop_ready;
  logic              busy;

  modport master (
    output snoop_in, bus_func, bus_addr, lk_tag_match, lk_stat,
    input  lk_req, lk_addr, data_rd, beat_idx, st_wr, st_new,
           snoop_hit, snoop_ready, busy
  );

  modport slave (
    input  snoop_in, bus_func, bus_addr, lk_tag_match, lk_stat,
    output lk_req, lk_addr, data_rd, beat_idx, st_wr, st_new,
           snoop_hit, snoop_ready, busy
  );
endinterface

// File: rtl/snoop_responder.sv
// Snoop responder: looks up a snooped line locally, streams its data beats on a hit,
// downgrades or invalidates the local copy, then signals completion with a one-cycle pulse.
module snoop_responder #(
  parameter int ADDR_W = 8,
  parameter int BEATS  = 4
) (
  input  logic               clk,
  input  logic               reset,
  snoop_responder_if.slave   bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    DRIVE  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] F_B_READ  = 2'b10;
  localparam logic [1:0] F_P_WRITE = 2'b01;
  localparam logic [1:0] ST_EXCL   = 2'b11;
  localparam logic [1:0] ST_SHRD   = 2'b10;
  localparam logic [1:0] ST_INVL   = 2'b00;
  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        func_r;
  logic [1:0]        stat_r;
  logic              hit_r;
  logic [3:0]        beat_r;
  logic              lk_req_r;
  logic              data_rd_r;
  logic              st_wr_r;
  logic [1:0]        st_new_r;
  logic              snoop_ready_r;
  logic              snoop_hit_r;
  logic              busy_r;

  logic              lookup_hit_s;
  logic              upd_wr_s;
  logic [1:0]        upd_new_s;

  assign lookup_hit_s = bus.lk_tag_match && (bus.lk_stat != ST_INVL);

  // Local state change owed for the captured snoop: invalidate on p_write, downgrade an exclusive line on b_read.
  always_comb begin
    upd_wr_s  = 1'b0;
    upd_new_s = 2'b00;
    if (func_r == F_P_WRITE) begin
      upd_wr_s  = 1'b1;
      upd_new_s = ST_INVL;
    end else if (stat_r == ST_EXCL) begin
      upd_wr_s  = 1'b1;
      upd_new_s = ST_SHRD;
    end else begin
      upd_wr_s  = 1'b0;
      upd_new_s = 2'b00;
    end
  end

  // Responder FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      addr_r        <= {ADDR_W{1'b0}};
      func_r        <= 2'b00;
      stat_r        <= 2'b00;
      hit_r         <= 1'b0;
      beat_r        <= 4'd0;
      lk_req_r      <= 1'b0;
      data_rd_r     <= 1'b0;
      st_wr_r       <= 1'b0;
      st_new_r      <= 2'b00;
      snoop_ready_r <= 1'b0;
      snoop_hit_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      lk_req_r      <= 1'b0;
      data_rd_r     <= 1'b0;
      st_wr_r       <= 1'b0;
      st_new_r      <= 2'b00;
      snoop_ready_r <= 1'b0;
      snoop_hit_r   <= 1'b0;
      busy_r        <= 1'b1;
      case (state_r)
        IDLE: begin
          if (bus.snoop_in && (bus.bus_func == F_B_READ || bus.bus_func == F_P_WRITE)) begin
            addr_r   <= bus.bus_addr;
            func_r   <= bus.bus_func;
            lk_req_r <= 1'b1;
            state_r  <= LOOKUP;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        LOOKUP: begin
          hit_r  <= lookup_hit_s;
          stat_r <= bus.lk_stat;
          if (lookup_hit_s) begin
            data_rd_r <= 1'b1;
            beat_r    <= 4'd0;
            state_r   <= DRIVE;
          end else begin
            snoop_ready_r <= 1'b1;
            snoop_hit_r   <= 1'b0;
            state_r       <= DONE;
          end
        end
        DRIVE: begin
          if (beat_r == LAST_BEAT) begin
            beat_r   <= 4'd0;
            st_wr_r  <= upd_wr_s;
            st_new_r <= upd_new_s;
            state_r  <= UPDATE;
          end else begin
            beat_r    <= beat_r + 4'd1;
            data_rd_r <= 1'b1;
            state_r   <= DRIVE;
          end
        end
        UPDATE: begin
          snoop_ready_r <= 1'b1;
          snoop_hit_r   <= hit_r;
          state_r       <= DONE;
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          beat_r  <= 4'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.lk_req      = lk_req_r;
  assign bus.lk_addr     = lk_req_r ? addr_r : {ADDR_W{1'b0}};
  assign bus.data_rd     = data_rd_r;
  assign bus.beat_idx    = beat_r;
  assign bus.st_wr       = st_wr_r;
  assign bus.st_new      = st_new_r;
  assign bus.snoop_hit   = snoop_hit_r;
  assign bus.snoop_ready = snoop_ready_r;
  assign bus.busy        = busy_r;
endmodule
